// File: rtl/abc_ddr_pair_serializer.sv
// Readout word serializer feeding the balanced 2:1 DDR output mux.
// A 2-entry FIFO buffers words; one registered (d0,d1) bit pair is presented per clock.
module abc_ddr_pair_serializer #(
  parameter int   WORD_W  = 16,
  parameter logic IDLE_D0 = 1'b1,
  parameter logic IDLE_D1 = 1'b0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ser_en,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              d0_out,
  output logic              d1_out,
  output logic              sow,
  output logic              busy
);

  localparam int PAIRS = WORD_W / 2;
  localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [WORD_W-1:0] fifo_mem [2];
  logic              rd_ptr_reg;
  logic              wr_ptr_reg;
  logic [1:0]        fifo_count_reg, fifo_count_next;

  // shreg holds only the pairs still to be presented, aligned to the MSB
  logic [WORD_W-1:0] shreg_reg, shreg_next;
  logic [WORD_W-1:0] shreg_shifted;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic d0_reg, d0_next;
  logic d1_reg, d1_next;
  logic sow_reg, sow_next;
  logic busy_reg, busy_next;

  logic              fifo_empty;
  logic              last_pair;
  logic              load;
  logic              push;
  logic [WORD_W-1:0] head_word;

  assign word_ready = (fifo_count_reg < 2'd2);
  assign fifo_empty = (fifo_count_reg == 2'd0);
  assign last_pair  = (cnt_reg == CNT_W'(PAIRS - 1));
  assign head_word  = fifo_mem[rd_ptr_reg];
  assign push       = word_valid && word_ready;
  // A load is the only FIFO pop; it happens from IDLE or seamlessly at the end of a word
  assign load       = ser_en && !fifo_empty && ((state_reg == IDLE) || last_pair);

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_shift
      if (gi < 2) begin : g_fill
        assign shreg_shifted[gi] = 1'b0;
      end else begin : g_move
        assign shreg_shifted[gi] = shreg_reg[gi-2];
      end
    end
  endgenerate

  always_comb begin
    fifo_count_next = fifo_count_reg;
    case ({push, load})
      2'b10:   fifo_count_next = fifo_count_reg + 2'd1;
      2'b01:   fifo_count_next = fifo_count_reg - 2'd1;
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_ptr_reg     <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      fifo_count_reg <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (load) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      fifo_count_reg <= fifo_count_next;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= word_in;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      d0_reg    <= IDLE_D0;
      d1_reg    <= IDLE_D1;
      sow_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      d0_reg    <= d0_next;
      d1_reg    <= d1_next;
      sow_reg   <= sow_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_pair && !load) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next   = '0;
    shreg_next = shreg_reg;
    d0_next    = IDLE_D0;
    d1_next    = IDLE_D1;
    sow_next   = 1'b0;
    busy_next  = 1'b0;
    if (load) begin
      cnt_next   = '0;
      shreg_next = {head_word[WORD_W-3:0], 2'b00};
      d0_next    = head_word[WORD_W-1];
      d1_next    = head_word[WORD_W-2];
      sow_next   = 1'b1;
      busy_next  = 1'b1;
    end else if ((state_reg == SHIFT) && !last_pair) begin
      cnt_next   = cnt_reg + CNT_W'(1);
      shreg_next = shreg_shifted;
      d0_next    = shreg_reg[WORD_W-1];
      d1_next    = shreg_reg[WORD_W-2];
      busy_next  = 1'b1;
    end
  end

  assign d0_out = d0_reg;
  assign d1_out = d1_reg;
  assign sow    = sow_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_abc_ddr_pair_serializer.sv
// Directed bench for abc_ddr_pair_serializer: word-level queue model checked every cycle,
// plus literal pair-stream expectations per scenario.
module tb_abc_ddr_pair_serializer;

  localparam int W     = 16;
  localparam int PAIRS = W / 2;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ser_en = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic         d0_out, d1_out, sow, busy;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  abc_ddr_pair_serializer #(.WORD_W(W), .IDLE_D0(1'b1), .IDLE_D1(1'b0)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ser_en     (ser_en),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .d0_out     (d0_out),
    .d1_out     (d1_out),
    .sow        (sow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: queue of pending words, current word, index of the pair on the wire
  logic [W-1:0] mq[$];
  logic [W-1:0] m_cur = '0;
  int           m_k = -1;
  logic         m_d0 = 1'b1, m_d1 = 1'b0, m_sow = 1'b0, m_busy = 1'b0;
  bit           m_push;
  logic [W-1:0] m_pw;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mq.delete();
      m_k = -1;
      m_d0 = 1'b1; m_d1 = 1'b0; m_sow = 1'b0; m_busy = 1'b0;
    end else begin
      m_push = word_valid && (mq.size() < 2);
      m_pw   = word_in;
      m_sow  = 1'b0;
      if (m_k < 0 || m_k == PAIRS - 1) begin
        if (ser_en && mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_k   = 0;
          m_sow = 1'b1;
        end else begin
          m_k = -1;
        end
      end else begin
        m_k++;
      end
      if (m_push) mq.push_back(m_pw);
      if (m_k >= 0) begin
        m_d0 = m_cur[W-1-2*m_k];
        m_d1 = m_cur[W-2-2*m_k];
        m_busy = 1'b1;
      end else begin
        m_d0 = 1'b1; m_d1 = 1'b0; m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("d0_out", 64'(d0_out), 64'(m_d0));
      chk("d1_out", 64'(d1_out), 64'(m_d1));
      chk("sow", 64'(sow), 64'(m_sow));
      chk("busy", 64'(busy), 64'(m_busy));
      if (rstb) chk("word_ready", 64'(word_ready), 64'(mq.size() < 2));
    end
  end

  // Capture of the emitted pair stream for literal checks
  logic [63:0] cap_bits = '0;
  int          cap_pairs = 0;
  int          cap_sow = 0;

  always @(negedge clk) begin
    if (rstb && busy) begin
      cap_bits = {cap_bits[61:0], d0_out, d1_out};
      cap_pairs++;
      if (sow) cap_sow++;
    end
  end

  task automatic clr_cap();
    @(posedge clk);
    cap_bits = '0;
    cap_pairs = 0;
    cap_sow = 0;
  endtask

  // Present a word from a falling edge and return just after the edge that accepts it
  task automatic push(input logic [W-1:0] w);
    bit r;
    bit done = 1'b0;
    @(negedge clk);
    word_valid = 1'b1;
    word_in = w;
    for (int i = 0; i < 50 && !done; i++) begin
      r = word_ready;
      @(posedge clk);
      if (r) done = 1'b1;
    end
    if (!done) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // Reset with clock running
    repeat (3) @(posedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_d0", 64'(d0_out), 64'd1);
    chk("rst_d1", 64'(d1_out), 64'd0);
    chk("rst_sow", 64'(sow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #2 rstb = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(word_ready), 64'd1);

    // Single word
    ser_en = 1'b1;
    clr_cap();
    push(16'hA5C3);
    @(negedge clk);
    word_valid = 1'b0;
    chk("single_busy_before", 64'(busy), 64'd0);
    @(negedge clk);
    chk("single_first_busy", 64'(busy), 64'd1);
    chk("single_first_sow", 64'(sow), 64'd1);
    chk("single_first_pair", 64'({d0_out, d1_out}), 64'd2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("single_pairs", 64'(cap_pairs), 64'd8);
    chk("single_bits", cap_bits[15:0], 64'h0000_0000_0000_A5C3);
    chk("single_sow_cnt", 64'(cap_sow), 64'd1);
    chk("single_idle", 64'({d0_out, d1_out, busy}), 64'b100);

    // Back-to-back plus third word
    clr_cap();
    push(16'hFFFF);
    push(16'h0000);
    push(16'h5A5A);
    @(negedge clk);
    word_valid = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("b2b_pairs", 64'(cap_pairs), 64'd24);
    chk("b2b_bits", 64'(cap_bits[47:0]), 64'h0000_FFFF_0000_5A5A);
    chk("b2b_sow_cnt", 64'(cap_sow), 64'd3);

    // Backpressure with the serializer disabled
    ser_en = 1'b0;
    clr_cap();
    push(16'h1111);
    push(16'h2222);
    @(negedge clk);
    word_valid = 1'b1;
    word_in = 16'h3333;
    chk("bp_ready_full", 64'(word_ready), 64'd0);
    @(negedge clk);
    chk("bp_ready_held", 64'(word_ready), 64'd0);
    chk("bp_busy_held", 64'(busy), 64'd0);
    ser_en = 1'b1;
    @(negedge clk);
    chk("bp_start_busy", 64'(busy), 64'd1);
    chk("bp_ready_back", 64'(word_ready), 64'd1);
    @(negedge clk);
    word_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("bp_pairs", 64'(cap_pairs), 64'd24);
    chk("bp_bits", 64'(cap_bits[47:0]), 64'h0000_1111_2222_3333);

    // Enable dropped at pair 3 with a second word queued
    clr_cap();
    push(16'h1234);
    push(16'hBEEF);
    @(negedge clk);
    word_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ser_en = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("en_idle", 64'({d0_out, d1_out, busy}), 64'b100);
    chk("en_pairs", 64'(cap_pairs), 64'd8);
    chk("en_bits", cap_bits[15:0], 64'h1234);
    ser_en = 1'b1;
    @(negedge clk);
    chk("en_resume_busy", 64'(busy), 64'd1);
    chk("en_resume_sow", 64'(sow), 64'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("en_total_pairs", 64'(cap_pairs), 64'd16);
    chk("en_total_bits", 64'(cap_bits[31:0]), 64'h1234_BEEF);

    // Reset at pair 4 with two words queued
    clr_cap();
    push(16'hC001);
    push(16'h0E0E);
    push(16'h7777);
    @(negedge clk);
    word_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("mr_idle", 64'({d0_out, d1_out, sow, busy}), 64'b1000);
    chk("mr_fifo_empty", 64'(word_ready), 64'd1);
    chk("mr_pairs_before", 64'(cap_pairs), 64'd5);
    chk("mr_bits_before", 64'(cap_bits[9:0]), 64'h300);
    @(negedge clk);
    #2 rstb = 1'b1;
    clr_cap();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mr_no_data", 64'(cap_pairs), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
